// File: rtl/arq_pkg.sv
// arq_pkg: shared types and constants for the ARQ retry sequencer.
// States, datapath error modes and a counter-width helper.
package arq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    WAIT,
    DONE,
    FAIL
  } arq_state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_1B   = 2'd1;
  localparam logic [1:0] ERR_2B   = 2'd2;
  localparam logic [1:0] ERR_DROP = 2'd3;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arq_timeout_timer.sv
// arq_timeout_timer: per-attempt wait timer.
// Cleared before each wait, counts while enabled, flags TIMEOUT-1.
module arq_timeout_timer
  import arq_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = cnt_w(TIMEOUT);

  logic [TW-1:0] cnt_q;
  logic          at_end;

  assign at_end = (cnt_q == TW'(TIMEOUT - 1));
  assign expire = en && at_end;

  // count wait cycles; hold at the last value so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !at_end) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

endmodule

// File: rtl/arq_retry_ctrl.sv
// arq_retry_ctrl: stop-and-wait ARQ sequencer for the ECC+FIFO datapath.
// Build option ARQ_STATS_EN adds saturating retry/fail counters.
module arq_retry_ctrl
  import arq_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 8,
  parameter int STAT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        err_mode_cfg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ok,
  output logic              dp_wr_en,
  output logic              dp_rd_en,
  output logic [DATA_W-1:0] dp_data_in,
  output logic [1:0]        dp_err_mode,
  input  logic [DATA_W-1:0] dp_data_out,
  input  logic              dp_ack,
  input  logic              dp_nack,
  output logic [STAT_W-1:0] stat_retries,
  output logic [STAT_W-1:0] stat_fails
);

  localparam int RW = cnt_w(MAX_RETRY + 1);

  arq_state_e        state_q;
  arq_state_e        state_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;
  logic [RW-1:0]     retry_q;
  logic [RW-1:0]     retry_d;
  logic              last_try;
  logic              att_ack;
  logic              att_fail;
  logic              tmo;

  arq_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == READ),
    .en    (state_q == WAIT),
    .expire(tmo)
  );

  // next state: nack beats ack, ack beats the timer
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    retry_d  = retry_q;
    att_ack  = 1'b0;
    att_fail = 1'b0;
    last_try = (retry_q == RW'(MAX_RETRY));
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          retry_d = '0;
          state_d = WRITE;
        end
      end
      WRITE: state_d = READ;
      READ:  state_d = WAIT;
      WAIT: begin
        if (dp_nack) begin
          att_fail = 1'b1;
        end else if (dp_ack) begin
          att_ack = 1'b1;
          state_d = DONE;
        end else if (tmo) begin
          att_fail = 1'b1;
        end
        if (att_fail) begin
          if (last_try) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + RW'(1);
            state_d = WRITE;
          end
        end
      end
      DONE, FAIL: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, payload hold and attempt counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      retry_q <= retry_d;
    end
  end

  // registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      dp_wr_en    <= 1'b0;
      dp_rd_en    <= 1'b0;
      dp_data_in  <= '0;
      dp_err_mode <= ERR_NONE;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE)
                || (state_d == FAIL);
      dp_wr_en  <= (state_d == WRITE);
      dp_rd_en  <= (state_d == READ);
      if (state_d == WRITE) begin
        dp_data_in  <= hold_d;
        dp_err_mode <= err_mode_cfg;
      end else begin
        dp_data_in  <= '0;
        dp_err_mode <= ERR_NONE;
      end
    end
  end

  // result: read-back data on ack, original payload when exhausted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ok   <= 1'b0;
    end else if (att_ack) begin
      out_data <= dp_data_out;
      out_ok   <= 1'b1;
    end else if (att_fail && last_try) begin
      out_data <= hold_q;
      out_ok   <= 1'b0;
    end
  end

`ifdef ARQ_STATS_EN
  logic [STAT_W-1:0] retries_q;
  logic [STAT_W-1:0] fails_q;

  // saturating retransmission and failure counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retries_q <= '0;
      fails_q   <= '0;
    end else begin
      if (att_fail && !last_try && (retries_q != '1))
        retries_q <= retries_q + STAT_W'(1);
      if (att_fail && last_try && (fails_q != '1))
        fails_q <= fails_q + STAT_W'(1);
    end
  end

  assign stat_retries = retries_q;
  assign stat_fails   = fails_q;
`else
  assign stat_retries = '0;
  assign stat_fails   = '0;
`endif

endmodule

// File: tb/tb_arq_retry_ctrl.sv
// tb_arq_retry_ctrl: table and random transactions for arq_retry_ctrl.
// A transaction-level model predicts latency, attempts and result.
module tb_arq_retry_ctrl;

  localparam int DW = 4;
  localparam int MR = 3;
  localparam int TO = 8;
  localparam int SW = 8;

  localparam logic [1:0] R_ACK  = 2'd0;
  localparam logic [1:0] R_NACK = 2'd1;
  localparam logic [1:0] R_NONE = 2'd2;
  localparam logic [1:0] R_BOTH = 2'd3;

  typedef struct packed {
    logic [3:0]      data;
    logic [1:0]      emode;
    logic [3:0]      rdata;
    logic [3:0][1:0] resp;
    logic [3:0][2:0] dly;
    bit              noise;
    int              hold;
    int              e_lat;
    int              e_wr;
    logic [3:0]      e_data;
    bit              e_ok;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    err_mode_cfg;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_ok;
  logic          dp_wr_en;
  logic          dp_rd_en;
  logic [DW-1:0] dp_data_in;
  logic [1:0]    dp_err_mode;
  logic [DW-1:0] dp_data_out;
  logic          dp_ack;
  logic          dp_nack;
  logic [SW-1:0] stat_retries;
  logic [SW-1:0] stat_fails;

  arq_retry_ctrl #(
    .DATA_W   (DW),
    .MAX_RETRY(MR),
    .TIMEOUT  (TO),
    .STAT_W   (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .err_mode_cfg(err_mode_cfg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ok      (out_ok),
    .dp_wr_en    (dp_wr_en),
    .dp_rd_en    (dp_rd_en),
    .dp_data_in  (dp_data_in),
    .dp_err_mode (dp_err_mode),
    .dp_data_out (dp_data_out),
    .dp_ack      (dp_ack),
    .dp_nack     (dp_nack),
    .stat_retries(stat_retries),
    .stat_fails  (stat_fails)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;
  int exp_retries;
  int exp_fails;
  vec_t tbl[8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] data, input logic [1:0] em,
    input logic [3:0] rd,
    input logic [1:0] r0, input int d0,
    input logic [1:0] r1, input int d1,
    input logic [1:0] r2, input int d2,
    input logic [1:0] r3, input int d3,
    input int hold, input int elat, input int ewr,
    input logic [3:0] edata, input bit eok);
    vec_t v;
    v = '0;
    v.data = data; v.emode = em; v.rdata = rd;
    v.resp[0] = r0; v.dly[0] = 3'(d0);
    v.resp[1] = r1; v.dly[1] = 3'(d1);
    v.resp[2] = r2; v.dly[2] = 3'(d2);
    v.resp[3] = r3; v.dly[3] = 3'(d3);
    v.hold = hold; v.e_lat = elat; v.e_wr = ewr;
    v.e_data = edata; v.e_ok = eok;
    return v;
  endfunction

  // attempt-by-attempt cost: 2 setup cycles plus the wait
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.e_lat = 0; r.e_wr = 0;
    r.e_ok = 1'b0; r.e_data = v.data;
    for (int a = 0; a <= MR; a++) begin
      r.e_wr++;
      if (v.resp[a] == R_NONE) r.e_lat += 2 + TO;
      else r.e_lat += 3 + int'(v.dly[a]);
      if (v.resp[a] == R_ACK) begin
        r.e_ok = 1'b1;
        r.e_data = v.rdata;
        break;
      end
    end
    r.e_lat += 1;
    return r;
  endfunction

  task automatic chk_stats();
    int er;
    int ef;
    int top;
    top = (1 << SW) - 1;
`ifdef ARQ_STATS_EN
    er = (exp_retries > top) ? top : exp_retries;
    ef = (exp_fails > top) ? top : exp_fails;
`else
    er = 0;
    ef = 0 * top;
`endif
    chk("stat_retries", 32'(stat_retries), er);
    chk("stat_fails", 32'(stat_fails), ef);
  endtask

  task automatic run(input vec_t v);
    int  cyc;
    int  wr;
    int  att;
    int  wcnt;
    bit  waiting;
    bit  prev_rd;
    bit  seen;
    err_mode_cfg = v.emode;
    in_data = v.data;
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = 4'($urandom);
    cyc = 1; wr = 0; att = -1; wcnt = 0;
    waiting = 0; prev_rd = 0; seen = 0;
    while (cyc < 400) begin
      dp_ack = 1'b0;
      dp_nack = 1'b0;
      dp_data_out = 4'($urandom);
      if (out_valid) begin
        seen = 1;
        break;
      end
      chk("in_ready_busy", in_ready, 0);
      chk("strobe_excl", dp_wr_en & dp_rd_en, 0);
      if (dp_wr_en) begin
        wr++; att++; waiting = 0;
        chk("dp_write", {dp_err_mode, dp_data_in},
            {v.emode, v.data});
      end else begin
        chk("dp_quiet", {dp_err_mode, dp_data_in}, 0);
      end
      if (prev_rd) begin
        waiting = 1; wcnt = 0;
      end else if (waiting) begin
        wcnt++;
      end
      if (waiting && att >= 0 && att <= MR) begin
        if (wcnt == int'(v.dly[att]) &&
            v.resp[att] != R_NONE) begin
          dp_ack  = (v.resp[att] != R_NACK);
          dp_nack = (v.resp[att] != R_ACK);
          dp_data_out = v.rdata;
        end
      end else if (v.noise) begin
        dp_ack  = 1'($urandom);
        dp_nack = 1'($urandom);
      end
      prev_rd = dp_rd_en;
      @(posedge clk); #1;
      cyc++;
    end
    chk("out_valid_seen", seen, 1);
    chk("latency", cyc, v.e_lat);
    chk("writes", wr, v.e_wr);
    chk("out_data", out_data, v.e_data);
    chk("out_ok", out_ok, v.e_ok);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", {out_ok, out_data},
          {v.e_ok, v.e_data});
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    exp_retries += v.e_wr - 1;
    exp_fails += v.e_ok ? 0 : 1;
    chk_stats();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out"}, {out_ok, out_data}, 0);
    chk({tag, "_strobes"}, {dp_wr_en, dp_rd_en}, 0);
    chk({tag, "_dp_in"}, {dp_err_mode, dp_data_in}, 0);
    chk_stats();
  endtask

  initial begin
    vec_t v;
    n_cmp = 0; n_bad = 0;
    exp_retries = 0; exp_fails = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    err_mode_cfg = '0; out_ready = 1'b0;
    dp_data_out = '0; dp_ack = 1'b0; dp_nack = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    tbl[0] = mk(4'hA, 2'd0, 4'hA,
                R_ACK, 0, R_ACK, 0, R_ACK, 0, R_ACK, 0,
                0, 4, 1, 4'hA, 1);
    tbl[1] = mk(4'h3, 2'd1, 4'h3,
                R_NACK, 1, R_NACK, 2, R_ACK, 0, R_ACK, 0,
                0, 13, 3, 4'h3, 1);
    tbl[2] = mk(4'hC, 2'd2, 4'h0,
                R_NACK, 0, R_NACK, 0, R_NACK, 0, R_NACK, 0,
                2, 13, 4, 4'hC, 0);
    tbl[3] = mk(4'h5, 2'd3, 4'h9,
                R_NONE, 0, R_NONE, 0, R_NONE, 0, R_NONE, 0,
                0, 41, 4, 4'h5, 0);
    tbl[4] = mk(4'h9, 2'd0, 4'h6,
                R_BOTH, 0, R_ACK, 0, R_ACK, 0, R_ACK, 0,
                10, 7, 2, 4'h6, 1);
    tbl[5] = mk(4'h1, 2'd1, 4'hE,
                R_ACK, 7, R_ACK, 0, R_ACK, 0, R_ACK, 0,
                0, 11, 1, 4'hE, 1);
    tbl[6] = mk(4'hF, 2'd2, 4'h2,
                R_NONE, 0, R_NONE, 0, R_NONE, 0, R_ACK, 7,
                1, 41, 4, 4'h2, 1);
    tbl[7] = mk(4'h0, 2'd3, 4'h8,
                R_NACK, 7, R_NACK, 0, R_NACK, 0, R_ACK, 0,
                0, 20, 4, 4'h8, 1);
    tbl[7].noise = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    err_mode_cfg = 2'd2;
    in_data = 4'h7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    exp_retries = 0;
    exp_fails = 0;
    chk_reset_outputs("midrst");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    run(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      v = '0;
      v.data  = 4'($urandom);
      v.emode = 2'($urandom);
      v.rdata = 4'($urandom);
      v.noise = 1'($urandom);
      v.hold  = $urandom_range(0, 3);
      for (int a = 0; a < 4; a++) begin
        v.resp[a] = 2'($urandom_range(0, 3));
        v.dly[a]  = 3'($urandom_range(0, TO - 1));
      end
      v = model(v);
      run(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
